// File: rtl/mem_port_arbiter_if.sv
// Request/ack bundle between the pipeline's IF/MEM stages, the shared-port
// arbiter and the single-port main RAM.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_data;
  logic              if_ack;

  logic              d_rd_n;
  logic              d_wr_n;
  logic              d_wh;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;

  logic              stall;
  logic              err;

  logic              ram_en;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  if_req, if_addr, d_rd_n, d_wr_n, d_wh, d_addr, d_wdata, ram_rdata,
    output if_data, if_ack, d_rdata, d_ack, stall, err,
           ram_en, ram_we, ram_be, ram_addr, ram_wdata
  );

  modport master (
    output if_req, if_addr, d_rd_n, d_wr_n, d_wh, d_addr, d_wdata, ram_rdata,
    input  if_data, if_ack, d_rdata, d_ack, stall, err,
           ram_en, ram_we, ram_be, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency RAM port between instruction fetch and data access,
// round-robin on contention, one access per MEM_LAT+3 cycles.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  typedef enum logic {REQ_IF, REQ_D} req_t;

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  state_t     state;
  req_t       token;
  req_t       grant;
  logic       grant_rd;
  logic [2:0] cnt;

  logic              d_req;
  logic              d_write;
  logic              pick_if;
  logic              sel_we;
  logic [3:0]        sel_be;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{bus.if_addr[1:0], bus.d_addr[0]};

  // RAM command for whichever requester wins this cycle's arbitration.
  always_comb begin
    d_req     = ~bus.d_rd_n | ~bus.d_wr_n;
    d_write   = ~bus.d_wr_n;
    pick_if   = bus.if_req & (~d_req | (token == REQ_IF));
    sel_we    = 1'b0;
    sel_be    = '1;
    sel_addr  = {bus.if_addr[ADDR_W-1:2], 2'b00};
    sel_wdata = '0;
    if (!pick_if) begin
      sel_addr = {bus.d_addr[ADDR_W-1:2], 2'b00};
      if (d_write) begin
        sel_we = 1'b1;
        if (bus.d_wh) begin
          sel_be    = bus.d_addr[1] ? 4'b1100 : 4'b0011;
          sel_wdata = {2{bus.d_wdata[15:0]}};
        end else begin
          sel_wdata = bus.d_wdata;
        end
      end
    end
  end

  assign bus.stall = (bus.if_req | d_req) & ~(bus.if_ack | bus.d_ack);

  // The RAM output registers double as the latched address/data/rd-wr/wh of
  // the grant: loaded on the grant edge so they are live exactly in ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      token         <= REQ_IF;
      grant         <= REQ_IF;
      grant_rd      <= 1'b0;
      cnt           <= '0;
      bus.if_ack    <= 1'b0;
      bus.if_data   <= '0;
      bus.d_ack     <= 1'b0;
      bus.d_rdata   <= '0;
      bus.err       <= 1'b0;
      bus.ram_en    <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_be    <= '0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
    end else begin
      bus.if_ack    <= 1'b0;
      bus.if_data   <= '0;
      bus.d_ack     <= 1'b0;
      bus.d_rdata   <= '0;
      bus.ram_en    <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_be    <= '0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      unique case (state)
        IDLE: begin
          if (~bus.d_rd_n & ~bus.d_wr_n) bus.err <= 1'b1;
          if (bus.if_req | d_req) begin
            grant    <= pick_if ? REQ_IF : REQ_D;
            grant_rd <= pick_if | ~d_write;
            if (bus.if_req & d_req) token <= (token == REQ_IF) ? REQ_D : REQ_IF;
            bus.ram_en    <= 1'b1;
            bus.ram_we    <= sel_we;
            bus.ram_be    <= sel_be;
            bus.ram_addr  <= sel_addr;
            bus.ram_wdata <= sel_wdata;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= LAT;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state <= ACK;
            if (grant == REQ_IF) begin
              bus.if_ack  <= 1'b1;
              bus.if_data <= bus.ram_rdata;
            end else begin
              bus.d_ack   <= 1'b1;
              bus.d_rdata <= grant_rd ? bus.ram_rdata : '0;
            end
          end
        end
        ACK: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
